// File: rtl/fwd_pkg.sv
// Shared types and select encodings for the EX-stage forwarding / load-use hazard logic.
package fwd_pkg;

  localparam int REG_W   = 5;
  localparam int NUM_OPS = 2;  // operand A (index 0), operand B (index 1)

  localparam logic [1:0] SEL_RF    = 2'b00;
  localparam logic [1:0] SEL_EXMEM = 2'b01;
  localparam logic [1:0] SEL_MEMWB = 2'b10;
  localparam logic [1:0] SEL_ALT   = 2'b11;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             is_load;
  } track_t;

  // A tracked producer hits a source only if it really writes a nonzero rd that is read.
  function automatic logic hit(input logic [REG_W-1:0] src, input logic used,
                               input track_t t);
    return t.valid & t.reg_write & (t.rd == src) & (src != '0) & used;
  endfunction

endpackage

// File: rtl/fwd_sel_calc.sv
// Priority operand-select for one EX operand: alternate source, then nearest producer.
module fwd_sel_calc
  import fwd_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  logic             alt,
  input  track_t           ex_t,
  input  track_t           mem_t,
  output logic [1:0]       sel
);

  always_comb begin
    sel = SEL_RF;
    if (alt)                        sel = SEL_ALT;
    else if (hit(src, used, ex_t))  sel = SEL_EXMEM;
    else if (hit(src, used, mem_t)) sel = SEL_MEMWB;
  end

  // Load flags only matter for stall detection, which lives in the top.
  logic unused_load;
  assign unused_load = ex_t.is_load ^ mem_t.is_load;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight writers across EX/MEM/WB, registers ALU operand selects, raises load-use stall.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = REG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_use_pc,
  input  logic                  id_use_imm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  flush,
  input  logic                  freeze,
  output logic                  stall,
  output logic [1:0]            ex_rs1_sel,
  output logic [1:0]            ex_rs2_sel
);

  track_t ex_t, mem_t, wb_t;

  logic [NUM_OPS-1:0][REG_W-1:0] src;
  logic [NUM_OPS-1:0]            used;
  logic [NUM_OPS-1:0]            alt;
  logic [NUM_OPS-1:0][1:0]       sel_nxt;
  logic [NUM_OPS-1:0]            ex_hit;

  assign src  = {id_rs2, id_rs1};
  assign used = {id_rs2_used, id_rs1_used};
  assign alt  = {id_use_imm, id_use_pc};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    fwd_sel_calc u_sel (
      .src   (src[g]),
      .used  (used[g]),
      .alt   (alt[g]),
      .ex_t  (ex_t),
      .mem_t (mem_t),
      .sel   (sel_nxt[g])
    );
    assign ex_hit[g] = hit(src[g], used[g], ex_t);
  end

  // Load data is not ready until MEM/WB, so an EX-stage load cannot feed the next instruction.
  assign stall = id_valid & ~flush & ex_t.is_load & (|ex_hit);

  logic   issue;
  track_t id_t;

  assign issue = id_valid & ~flush & ~stall;
  assign id_t  = '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_t       <= '0;
      mem_t      <= '0;
      wb_t       <= '0;
      ex_rs1_sel <= SEL_RF;
      ex_rs2_sel <= SEL_RF;
    end else if (!freeze) begin
      wb_t  <= mem_t;
      mem_t <= ex_t;
      if (issue) begin
        ex_t       <= id_t;
        ex_rs1_sel <= sel_nxt[0];
        ex_rs2_sel <= sel_nxt[1];
      end else begin
        ex_t       <= '0;
        ex_rs1_sel <= SEL_RF;
        ex_rs2_sel <= SEL_RF;
      end
    end
  end

  // WB stage is tracked for completeness; the regfile writes through, so it never forwards.
  logic unused_wb;
  assign unused_wb = ^wb_t;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding selects, load-use stall, flush, freeze, reset.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used, id_use_pc, id_use_imm;
  logic       id_reg_write, id_is_load;
  logic       flush, freeze;
  logic       stall;
  logic [1:0] ex_rs1_sel, ex_rs2_sel;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_use_pc    (id_use_pc),
    .id_use_imm   (id_use_imm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .flush        (flush),
    .freeze       (freeze),
    .stall        (stall),
    .ex_rs1_sel   (ex_rs1_sel),
    .ex_rs2_sel   (ex_rs2_sel)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
    end
  endtask

  // Drive an ID instruction: valid, rs1/used, rs2/used, use_pc, use_imm, rd, reg_write, is_load.
  task automatic id_set(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic pc,
                        input logic imm, input logic [4:0] rd, input logic rw,
                        input logic ld);
    id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2; id_rs2_used = u2;
    id_use_pc = pc; id_use_imm = imm; id_rd = rd; id_reg_write = rw; id_is_load = ld;
  endtask

  task automatic bubble();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    id_set(1, 5'd1, 1, 5'd2, 1, 0, 0, 5'd1, 1, 1);
    step(); step();
    chk("rst_sel1", ex_rs1_sel, 2'b00);
    chk("rst_sel2", ex_rs2_sel, 2'b00);
    rst = 1'b0;
    bubble();
    #1 chk("rst_stall", {1'b0, stall}, 2'b00);

    // 1: ADD x5 then reader of rs1=x5 -> EX/MEM forward
    id_set(1, 5'd1, 1, 5'd2, 1, 0, 0, 5'd5, 1, 0); step();
    id_set(1, 5'd5, 1, 5'd4, 1, 0, 0, 5'd6, 1, 0);
    #1 chk("t1_stall", {1'b0, stall}, 2'b00);
    step();
    chk("t1_sel1", ex_rs1_sel, 2'b01);
    chk("t1_sel2", ex_rs2_sel, 2'b00);

    // 2: ADD x5; NOP; reader rs2=x5 -> MEM/WB forward
    bubble(); step(); step();
    id_set(1, 5'd1, 1, 5'd2, 1, 0, 0, 5'd5, 1, 0); step();
    bubble(); step();
    id_set(1, 5'd1, 1, 5'd5, 1, 0, 0, 5'd8, 1, 0); step();
    chk("t2_sel1", ex_rs1_sel, 2'b00);
    chk("t2_sel2", ex_rs2_sel, 2'b10);

    // 3: LW x7 then reader rs1=x7 -> one stall, bubble, then MEM/WB forward
    id_set(1, 5'd1, 1, 5'd0, 0, 0, 1, 5'd7, 1, 1); step();
    id_set(1, 5'd7, 1, 5'd2, 1, 0, 0, 5'd9, 1, 0);
    #1 chk("t3_stall", {1'b0, stall}, 2'b01);
    step();
    chk("t3_bubble_sel1", ex_rs1_sel, 2'b00);
    chk("t3_stall_clear", {1'b0, stall}, 2'b00);
    step();
    chk("t3_sel1", ex_rs1_sel, 2'b10);

    // 4: load writing x0, then reader of x0 -> no stall, no forward
    id_set(1, 5'd1, 1, 5'd0, 0, 0, 1, 5'd0, 1, 1); step();
    id_set(1, 5'd0, 1, 5'd0, 1, 0, 0, 5'd10, 1, 0);
    #1 chk("t4_stall", {1'b0, stall}, 2'b00);
    step();
    chk("t4_sel1", ex_rs1_sel, 2'b00);
    chk("t4_sel2", ex_rs2_sel, 2'b00);

    // 5: x3 in both EX and MEM -> nearest wins; imm overrides operand B
    id_set(1, 5'd1, 1, 5'd2, 1, 0, 0, 5'd3, 1, 0); step();
    id_set(1, 5'd4, 1, 5'd2, 1, 0, 0, 5'd3, 1, 0); step();
    id_set(1, 5'd3, 1, 5'd3, 1, 0, 1, 5'd12, 1, 0); step();
    chk("t5_sel1", ex_rs1_sel, 2'b01);
    chk("t5_sel2", ex_rs2_sel, 2'b11);

    // 6: load-use with flush -> no stall, bubble; flushed rd=x11 never tracked
    id_set(1, 5'd1, 1, 5'd0, 0, 0, 1, 5'd10, 1, 1); step();
    id_set(1, 5'd10, 1, 5'd2, 1, 0, 0, 5'd11, 1, 0); flush = 1'b1;
    #1 chk("t6_stall", {1'b0, stall}, 2'b00);
    step();
    flush = 1'b0;
    chk("t6_bubble_sel1", ex_rs1_sel, 2'b00);
    id_set(1, 5'd10, 1, 5'd10, 1, 1, 0, 5'd12, 1, 0); step();
    chk("t6_pc_sel1", ex_rs1_sel, 2'b11);
    chk("t6_sel2", ex_rs2_sel, 2'b10);
    id_set(1, 5'd11, 1, 5'd11, 1, 0, 0, 5'd13, 1, 0); step();
    chk("t6_noflushed_sel1", ex_rs1_sel, 2'b00);

    // Freeze for 3 cycles: selects and tracking hold
    id_set(1, 5'd1, 1, 5'd2, 1, 0, 0, 5'd13, 1, 0); step();
    id_set(1, 5'd13, 1, 5'd2, 1, 0, 0, 5'd14, 1, 0); step();
    chk("fz_pre_sel1", ex_rs1_sel, 2'b01);
    bubble(); freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fz_hold_sel1", ex_rs1_sel, 2'b01);
    end
    freeze = 1'b0;
    id_set(1, 5'd14, 1, 5'd13, 1, 0, 0, 5'd15, 1, 0); step();
    chk("fz_post_sel1", ex_rs1_sel, 2'b01);
    chk("fz_post_sel2", ex_rs2_sel, 2'b10);

    // Reset mid-stream: pending load must not stall or forward afterwards
    id_set(1, 5'd15, 1, 5'd0, 0, 0, 1, 5'd16, 1, 1); step();
    rst = 1'b1;
    id_set(1, 5'd16, 1, 5'd16, 1, 0, 0, 5'd17, 1, 0); step();
    rst = 1'b0;
    chk("mrst_sel1", ex_rs1_sel, 2'b00);
    chk("mrst_sel2", ex_rs2_sel, 2'b00);
    #1 chk("mrst_stall", {1'b0, stall}, 2'b00);
    step();
    chk("mrst_next_sel1", ex_rs1_sel, 2'b00);
    chk("mrst_next_sel2", ex_rs2_sel, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
